accum_status: RTL and testbench
===============================

Name: accum_status

Overview:
- Consumer end of the time-base enables: takes the TIC and accumulation-interrupt strobes plus per-channel dump strobes and turns them into CPU-facing status.
- Provides sticky flags, a per-channel new-data snapshot, overrun detection and the accumulator interrupt line.
- Sits between the time base / channel correlators and the CPU bus register decode; all bus reads arrive as one-cycle read strobes.

Parameters:
NUM_CHAN, 12, number of correlator channels (1..32)
TIC_CNT_W, 32, width of TIC event counter

Ports:
clk  input  1  system clock (sample clock domain)
rst  input  1  asynchronous active-high reset
tic_enable  input  1  one-cycle TIC strobe from time base
accum_enable  input  1  one-cycle accumulation-interrupt strobe from time base
dump  input  NUM_CHAN  per-channel one-cycle dump strobes from correlators
rd_status  input  1  one-cycle strobe: CPU read of status register (clear-on-read)
rd_new_data  input  1  one-cycle strobe: CPU read of new_data register (clear-on-read)
status  output  2  {accum_flag, tic_flag}
new_data  output  NUM_CHAN  channels that dumped during the last completed accum interval
overrun  output  NUM_CHAN  sticky per-channel data-loss flags
tic_count  output  TIC_CNT_W  number of TICs since reset
accum_int  output  1  accumulator interrupt, level, active-high

Behaviour:
- Reset is asynchronous, active-high. All outputs are 0 during reset; internal pending vector is 0.
- All outputs are registered. Every effect appears on the clock edge after the causing strobe (1-cycle latency).
- pending[i]:
  - dump[i] sets pending[i].
  - accum_enable copies pending into new_data and clears pending. A dump[i] in the same cycle as accum_enable leaves pending[i]=1 (it belongs to the next interval).
- new_data:
  - Loaded only on accum_enable.
  - rd_new_data clears it to 0.
  - accum_enable together with rd_new_data: the new snapshot wins (loaded, not cleared).
- overrun[i] is sticky and sets on either condition:
  - (a) dump[i] while pending[i]=1, i.e. a second dump within one interval.
  - (b) accum_enable while new_data[i]=1 and pending[i]=1 and rd_new_data=0, i.e. an unread snapshot is overwritten.
- overrun clears on rd_new_data. If a set condition occurs in the same cycle, set wins.
- tic_flag:
  - Set by tic_enable, cleared by rd_status; set wins when both occur together.
  - tic_count increments on each tic_enable, modulo 2^TIC_CNT_W; all-ones wraps to 0.
- accum_flag:
  - Set by accum_enable, cleared by rd_status; set wins when both occur together.
- accum_int equals accum_flag (registered), subject to the optional mask below.
- No state machine beyond the flags. Multiple strobes in one cycle are processed independently per the rules above.
- Reset asserted mid-operation clears everything immediately, including any strobe in flight; counting resumes from 0 after release.

Optional Feature:
- Macro ACCUM_INT_MASK_EN.
- Defined:
  - Adds input port int_mask (1 bit).
  - accum_int = accum_flag & ~int_mask.
  - accum_flag still sets and clears normally while masked.
  - Unmasking with accum_flag=1 asserts accum_int on the next cycle.
- Undefined: port absent; accum_int = accum_flag.

Test Plan:
- Reset release, no strobes for 100 cycles -> status=2'b00, new_data=0, overrun=0, tic_count=0, accum_int=0.
- dump[3] at cycle 10, accum_enable at cycle 20 -> new_data=0x008, status[1]=1 and accum_int=1 from cycle 21; rd_status at 30 -> status=0, accum_int=0 at 31; rd_new_data at 32 -> new_data=0 at 33.
- dump[5] at cycles 10 and 15, accum_enable at 20 -> overrun[5]=1 from cycle 16; new_data[5]=1; rd_new_data clears both.
- dump[0] same cycle as accum_enable, second accum_enable 50 cycles later with no read -> first snapshot new_data[0]=0; second snapshot new_data[0]=1, overrun[0]=0. A third interval with dump[0] and no read between snapshots -> overrun[0]=1.
- rd_status coincident with tic_enable -> tic_flag remains 1. 2^TIC_CNT_W tic_enable pulses (TIC_CNT_W=4 build) -> tic_count returns to 0 after 16.
- ACCUM_INT_MASK_EN build: int_mask=1, accum_enable -> accum_flag=1, accum_int=0; int_mask drops to 0 -> accum_int=1 on the next cycle. Assert rst mid-interval with pending=0xFFF -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/accum_status.sv
// ---------------------------------------------------------------------------
// accum_status
//
// Consumer end of the time-base enables. Turns the TIC strobe, the
// accumulation-interrupt strobe and the per-channel dump strobes into
// CPU-facing status: sticky flags, a per-channel new-data snapshot,
// overrun detection, a TIC event counter and the accumulator interrupt.
// Every output is registered, so each effect appears one clock after the
// strobe that caused it.
//
// Optional feature (compile-time macro ACCUM_INT_MASK_EN):
//   When defined, adds the int_mask input. accum_int is then forced low
//   while int_mask=1, but accum_flag keeps setting and clearing normally.
//   When undefined, the port is absent and accum_int follows accum_flag.
//
// Parameters:
//   NUM_CHAN   number of correlator channels (1..32)
//   TIC_CNT_W  width of the TIC event counter
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   int_mask      (ACCUM_INT_MASK_EN only) masks accum_int when high
//   tic_enable    one-cycle TIC strobe
//   accum_enable  one-cycle accumulation-interrupt strobe
//   dump          per-channel one-cycle dump strobes
//   rd_status     one-cycle CPU read of status (clears both flags)
//   rd_new_data   one-cycle CPU read of new_data (clears new_data, overrun)
//   status        {accum_flag, tic_flag}
//   new_data      channels that dumped in the last completed interval
//   overrun       sticky per-channel data-loss flags
//   tic_count     TICs since reset, wraps modulo 2^TIC_CNT_W
//   accum_int     accumulator interrupt, level, active-high
// ---------------------------------------------------------------------------
module accum_status #(
  parameter int NUM_CHAN  = 12,
  parameter int TIC_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ACCUM_INT_MASK_EN
  input  logic                 int_mask,
`endif
  input  logic                 tic_enable,
  input  logic                 accum_enable,
  input  logic [NUM_CHAN-1:0]  dump,
  input  logic                 rd_status,
  input  logic                 rd_new_data,
  output logic [1:0]           status,
  output logic [NUM_CHAN-1:0]  new_data,
  output logic [NUM_CHAN-1:0]  overrun,
  output logic [TIC_CNT_W-1:0] tic_count,
  output logic                 accum_int
);

  logic                mask_active;
  logic [NUM_CHAN-1:0] pending;

  logic [NUM_CHAN-1:0] pending_nxt;
  logic [NUM_CHAN-1:0] new_data_nxt;
  logic [NUM_CHAN-1:0] overrun_set;
  logic [NUM_CHAN-1:0] overrun_nxt;
  logic                tic_flag_nxt;
  logic                accum_flag_nxt;

`ifdef ACCUM_INT_MASK_EN
  assign mask_active = int_mask;
`else
  assign mask_active = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps this block latch-free.
    pending_nxt    = pending | dump;
    new_data_nxt   = new_data;
    overrun_set    = dump & pending;  // second dump within one interval
    tic_flag_nxt   = status[0];
    accum_flag_nxt = status[1];

    if (rd_new_data)
      new_data_nxt = '0;

    if (accum_enable) begin
      // A dump arriving together with accum_enable belongs to the next
      // interval, so it survives in pending while the old contents move out.
      pending_nxt  = dump;
      new_data_nxt = pending;  // a fresh snapshot wins over a coincident read
      if (!rd_new_data)
        overrun_set = overrun_set | (new_data & pending);  // unread snapshot lost
    end

    // Clear-on-read, but a set in the same cycle wins.
    overrun_nxt = (rd_new_data ? '0 : overrun) | overrun_set;

    if (rd_status) begin
      tic_flag_nxt   = 1'b0;
      accum_flag_nxt = 1'b0;
    end
    if (tic_enable)
      tic_flag_nxt = 1'b1;
    if (accum_enable)
      accum_flag_nxt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      new_data  <= '0;
      overrun   <= '0;
      status    <= 2'b00;
      tic_count <= '0;
      accum_int <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      new_data  <= new_data_nxt;
      overrun   <= overrun_nxt;
      status    <= {accum_flag_nxt, tic_flag_nxt};
      if (tic_enable)
        tic_count <= tic_count + 1'b1;  // wraps naturally at all-ones
      // Built from the next flag value so the interrupt rises in the same
      // cycle as accum_flag rather than one cycle later.
      accum_int <= accum_flag_nxt & ~mask_active;
    end
  end

endmodule

// File: tb/tb_accum_status.sv
// ---------------------------------------------------------------------------
// tb_accum_status
//
// Directed-vector bench for accum_status (NUM_CHAN=12, TIC_CNT_W=4).
// The driver applies one cycle of strobes per step and queues the
// hand-computed outputs expected after that clock edge; an independent
// monitor pops the queue on each falling edge and compares.
// Define ACCUM_INT_MASK_EN to exercise the interrupt mask as well.
// ---------------------------------------------------------------------------
module tb_accum_status;

  localparam int NC = 12;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]    status;
    logic [NC-1:0] new_data;
    logic [NC-1:0] overrun;
    logic [CW-1:0] tic_count;
    logic          accum_int;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          int_mask = 1'b0;
  logic          tic_enable = 1'b0;
  logic          accum_enable = 1'b0;
  logic [NC-1:0] dump = '0;
  logic          rd_status = 1'b0;
  logic          rd_new_data = 1'b0;
  logic [1:0]    status;
  logic [NC-1:0] new_data;
  logic [NC-1:0] overrun;
  logic [CW-1:0] tic_count;
  logic          accum_int;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_id = 0;

  accum_status #(.NUM_CHAN(NC), .TIC_CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ACCUM_INT_MASK_EN
    .int_mask     (int_mask),
`endif
    .tic_enable   (tic_enable),
    .accum_enable (accum_enable),
    .dump         (dump),
    .rd_status    (rd_status),
    .rd_new_data  (rd_new_data),
    .status       (status),
    .new_data     (new_data),
    .overrun      (overrun),
    .tic_count    (tic_count),
    .accum_int    (accum_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".status"},    32'(status),    32'(e.status));
    check({tag, ".new_data"},  32'(new_data),  32'(e.new_data));
    check({tag, ".overrun"},   32'(overrun),   32'(e.overrun));
    check({tag, ".tic_count"}, 32'(tic_count), 32'(e.tic_count));
    check({tag, ".accum_int"}, 32'(accum_int), 32'(e.accum_int));
  endtask

  // One clock of stimulus; the outputs expected after the edge are queued.
  task automatic step(input logic tic, input logic acc, input logic [NC-1:0] dmp,
                      input logic rs, input logic rn,
                      input logic [1:0] es, input logic [NC-1:0] en,
                      input logic [NC-1:0] eo, input logic [CW-1:0] ec,
                      input logic ei);
    exp_t e;
    tic_enable   = tic;
    accum_enable = acc;
    dump         = dmp;
    rd_status    = rs;
    rd_new_data  = rn;
    e = '{status: es, new_data: en, overrun: eo, tic_count: ec, accum_int: ei};
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    tic_enable   = 1'b0;
    accum_enable = 1'b0;
    dump         = '0;
    rd_status    = 1'b0;
    rd_new_data  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_id++;
        check_all($sformatf("step%0d", step_id), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs must be zero while reset is held, before any clock edge.
    #3;
    check_all("in_reset", '0);
    @(negedge clk);
    rst = 1'b0;

    // Quiet period after reset release.
    idle(100);
    step(0, 0, '0, 0, 0, 2'b00, '0, '0, 4'd0, 0);

    // Single dump on channel 3, then snapshot, status read, data read.
    step(0, 0, 12'h008, 0, 0, 2'b00, 12'h000, '0, 4'd0, 0);
    idle(9);
    step(0, 1, '0, 0, 0, 2'b10, 12'h008, '0, 4'd0, 1);
    idle(9);
    step(0, 0, '0, 0, 0, 2'b10, 12'h008, '0, 4'd0, 1);
    step(0, 0, '0, 1, 0, 2'b00, 12'h008, '0, 4'd0, 0);
    idle(1);
    step(0, 0, '0, 0, 1, 2'b00, 12'h000, '0, 4'd0, 0);

    // Two dumps on channel 5 within one interval -> overrun[5].
    step(0, 0, 12'h020, 0, 0, 2'b00, 12'h000, 12'h000, 4'd0, 0);
    idle(4);
    step(0, 0, 12'h020, 0, 0, 2'b00, 12'h000, 12'h020, 4'd0, 0);
    step(0, 1, '0, 0, 0, 2'b10, 12'h020, 12'h020, 4'd0, 1);
    step(0, 0, '0, 0, 1, 2'b10, 12'h000, 12'h000, 4'd0, 1);
    step(0, 0, '0, 1, 0, 2'b00, 12'h000, 12'h000, 4'd0, 0);

    // Dump coincident with accum_enable goes to the next interval.
    step(0, 1, 12'h001, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 1);
    idle(48);
    step(0, 1, '0, 0, 0, 2'b10, 12'h001, 12'h000, 4'd0, 1);
    // Third interval: unread snapshot overwritten -> overrun[0].
    step(0, 0, 12'h001, 0, 0, 2'b10, 12'h001, 12'h000, 4'd0, 1);
    step(0, 1, '0, 0, 0, 2'b10, 12'h001, 12'h001, 4'd0, 1);

    // accum_enable with rd_new_data: new snapshot loaded, overrun cleared.
    step(0, 0, 12'h002, 0, 0, 2'b10, 12'h001, 12'h001, 4'd0, 1);
    step(0, 1, '0, 0, 1, 2'b10, 12'h002, 12'h000, 4'd0, 1);
    step(0, 0, '0, 1, 0, 2'b00, 12'h002, 12'h000, 4'd0, 0);

    // rd_status coincident with tic_enable: tic_flag stays set.
    step(1, 0, '0, 1, 0, 2'b01, 12'h002, 12'h000, 4'd1, 0);
    step(0, 0, '0, 1, 0, 2'b00, 12'h002, 12'h000, 4'd1, 0);
    // Fifteen more TICs: counter wraps to 0 after the sixteenth.
    for (int i = 2; i <= 16; i++) begin
      logic [CW-1:0] c;
      c = CW'(i);
      step(1, 0, '0, 0, 0, 2'b01, 12'h002, 12'h000, c, 0);
    end
    // accum_enable coincident with rd_status: accum_flag set wins.
    step(0, 1, '0, 1, 0, 2'b10, 12'h000, 12'h000, 4'd0, 1);

`ifdef ACCUM_INT_MASK_EN
    // Masked interrupt: flag sets, line stays low until unmasked.
    int_mask = 1'b1;
    step(0, 0, '0, 1, 0, 2'b00, 12'h000, 12'h000, 4'd0, 0);
    step(0, 1, '0, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 0);
    step(0, 0, '0, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 0);
    int_mask = 1'b0;
    step(0, 0, '0, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 1);
`endif

    // All channels pending, then asynchronous reset mid-cycle.
    step(0, 0, 12'hFFF, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 1);
    step(1, 0, '0, 0, 0, 2'b11, 12'h000, 12'h000, 4'd1, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_reset", '0);
    @(negedge clk);
    rst = 1'b0;
    // Pending was wiped: the next snapshot is empty; counting restarts at 0.
    step(0, 1, '0, 0, 0, 2'b10, 12'h000, 12'h000, 4'd0, 1);
    step(1, 0, '0, 0, 0, 2'b11, 12'h000, 12'h000, 4'd1, 1);

    // Let the monitor drain; anything left is a failure.
    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
